// File: rtl/serial_shift_ctrl.sv
// LSB-first serializer controller: captures a word on a valid/ready handshake and
// shifts it out one bit per DIV clocks. Optional trailing even-parity bit: SERIAL_SHIFT_CTRL_PARITY_EN.
module serial_shift_ctrl #(
  parameter int NBITS = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(NBITS - 1);

  // Handshake: a word transfers on a rising edge where din_valid && din_ready;
  // the producer holds din/din_valid stable until then.
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [NBITS-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             tick_last;
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
  logic             par_q, par_d;
`endif

  assign tick_last = (tick_q == TICK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      tick_q  <= '0;
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      tick_q  <= tick_d;
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          sreg_d  = din;
          bit_d   = '0;
          tick_d  = '0;
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
          par_d   = ^din;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_last) begin
          tick_d = '0;
          sreg_d = sreg_q >> 1;
          // Counter parks at 0 after the last bit instead of wrapping past NBITS-1.
          if (bit_q == BIT_MAX) begin
            bit_d = '0;
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
      PARITY: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = DONE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; din never reaches so combinationally.
  always_comb begin
    din_ready = (state_q == IDLE);
    done      = (state_q == DONE);
    busy      = (state_q == SHIFT);
    so        = (state_q == SHIFT) ? sreg_q[0] : 1'b0;
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
    if (state_q == PARITY) begin
      busy = 1'b1;
      so   = par_q;
    end
`endif
  end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Bench for serial_shift_ctrl: two instances (DIV=1 and DIV=3) checked cycle by cycle
// against an expected-waveform queue built from the timing rules.
module tb_serial_shift_ctrl;

  localparam int NBITS = 4;
`ifdef SERIAL_SHIFT_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NBITS-1:0] din_a = '0, din_b = '0;
  logic v_a = 1'b0, v_b = 1'b0;
  logic r_a, so_a, busy_a, done_a;
  logic r_b, so_b, busy_b, done_b;

  int tests  = 0;
  int failed = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  serial_shift_ctrl #(.NBITS(NBITS), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(v_a),
    .din_ready(r_a), .so(so_a), .busy(busy_a), .done(done_a)
  );

  serial_shift_ctrl #(.NBITS(NBITS), .DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(v_b),
    .din_ready(r_b), .so(so_b), .busy(busy_b), .done(done_b)
  );

  // Observation vector {din_ready, so, busy, done} of instance s (0: DIV=1, 1: DIV=3).
  function automatic logic [3:0] obs(input int s);
    return (s != 0) ? {r_b, so_b, busy_b, done_b} : {r_a, so_a, busy_a, done_a};
  endfunction

  function automatic int div_of(input int s);
    return (s != 0) ? 3 : 1;
  endfunction

  // Expected observation c cycles after accepting word w.
  function automatic logic [3:0] exp_at(input int div, input logic [NBITS-1:0] w, input int c);
    int nb;
    nb = NBITS * div;
    if (c <= nb)                 return {1'b0, w[(c - 1) / div], 1'b1, 1'b0};
    if (c <= nb + PAR * div)     return {1'b0, ^w, 1'b1, 1'b0};
    if (c == nb + PAR * div + 1) return 4'b0001;
    return 4'b1000;
  endfunction

  task automatic set_in(input int s, input logic v, input logic [NBITS-1:0] d);
    if (s != 0) begin v_b = v; din_b = d; end
    else        begin v_a = v; din_a = d; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer word w now (DUT idle), check every cycle through the return of din_ready.
  // With hold=1 the next word nxt is presented during the whole transfer.
  task automatic run_word(input int s, input logic [NBITS-1:0] w,
                          input logic hold, input logic [NBITS-1:0] nxt);
    int div, last;
    logic [3:0] got, exp;
    div  = div_of(s);
    last = NBITS * div + PAR * div + 2;
    for (int c = 1; c <= last; c++) exp_q.push_back(exp_at(div, w, c));
    set_in(s, 1'b1, w);
    for (int c = 1; c <= last; c++) begin
      tick();
      if (hold) set_in(s, 1'b1, nxt);
      else      set_in(s, 1'b0, NBITS'($urandom));
      got = obs(s);
      exp = exp_q.pop_front();
      tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL word div=%0d w=%b cycle %0d: {rdy,so,busy,done} got %b expected %b",
                 div, w, c, got, exp);
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      for (int s = 0; s < 2; s++) begin
        tests++;
        if (obs(s) !== 4'b1000) begin
          failed++;
          $display("FAIL %s div=%0d cycle %0d: {rdy,so,busy,done} got %b expected 1000",
                   name, div_of(s), c, obs(s));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    check_idle("reset", 2);
    // Reset and valid together: reset wins, nothing captured.
    set_in(0, 1'b1, 4'b1111);
    set_in(1, 1'b1, 4'b1111);
    check_idle("rst_vs_valid", 1);
    rst = 1'b0;
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    check_idle("post_reset", 1);
  endtask

  task automatic test_idle();
    check_idle("idle", 20);
  endtask

  task automatic test_basic();
    run_word(0, 4'b1011, 1'b0, '0);
    run_word(0, 4'b0111, 1'b0, '0);
    run_word(0, 4'b0011, 1'b0, '0);
  endtask

  task automatic test_clock_div();
    run_word(1, 4'b0110, 1'b0, '0);
    run_word(1, 4'b1001, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    run_word(0, 4'b1011, 1'b1, 4'b0001);
    run_word(0, 4'b0001, 1'b0, '0);
    run_word(1, 4'b1101, 1'b1, 4'b0100);
    run_word(1, 4'b0100, 1'b0, '0);
  endtask

  task automatic test_mid_reset();
    logic [3:0] got;
    set_in(0, 1'b1, 4'b1111);
    tick();
    set_in(0, 1'b0, '0);
    tick();
    tests++;
    got = obs(0);
    if (got !== 4'b0110) begin
      failed++;
      $display("FAIL mid_reset_pre: {rdy,so,busy,done} got %b expected 0110", got);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    got = obs(0);
    if (got !== 4'b1000) begin
      failed++;
      $display("FAIL mid_reset_edge: {rdy,so,busy,done} got %b expected 1000", got);
    end
    check_idle("mid_reset_after", 10);
  endtask

  task automatic test_random();
    int s, gap;
    logic [NBITS-1:0] w, nxt;
    logic hold;
    for (int i = 0; i < 24; i++) begin
      s    = $urandom_range(0, 1);
      w    = NBITS'($urandom);
      nxt  = NBITS'($urandom);
      hold = 1'($urandom_range(0, 1));
      run_word(s, w, hold, nxt);
      if (hold) run_word(s, nxt, 1'b0, '0);
      gap = $urandom_range(0, 3);
      if (gap > 0) check_idle("random_gap", gap);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_clock_div();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
